// File: rtl/br_pkg.sv
// Shared definitions for the branch controller: funct3 codes, FSM states, decode fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package br_pkg;

    // RV32I B-type funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        RESP  = 2'd2,
        FLUSH = 2'd3
    } br_state_t;

    // How the shared comparator result turns into a taken decision
    typedef struct packed {
        logic unsign;    // comparator runs unsigned
        logic use_less;  // use the less-than result instead of equality
        logic invert;    // taken on the negated comparison
        logic illegal;   // funct3 is not a branch opcode
    } br_dec_t;

endpackage

// File: rtl/br_decode.sv
// Maps a branch funct3 to comparator mode and taken-condition selection.
// Latency: purely combinational.
// Backpressure: none.
module br_decode
    import br_pkg::*;
(
    input  logic [2:0] funct3,
    output br_dec_t    dec
);

    // Decode funct3; the unsigned flag is funct3[1] for every encoding, legal or not
    always_comb begin
        dec        = '0;
        dec.unsign = funct3[1];
        case (funct3)
            F3_BEQ:  begin dec.use_less = 1'b0; dec.invert = 1'b0; end
            F3_BNE:  begin dec.use_less = 1'b0; dec.invert = 1'b1; end
            F3_BLT:  begin dec.use_less = 1'b1; dec.invert = 1'b0; end
            F3_BGE:  begin dec.use_less = 1'b1; dec.invert = 1'b1; end
            F3_BLTU: begin dec.use_less = 1'b1; dec.invert = 1'b0; end
            F3_BGEU: begin dec.use_less = 1'b1; dec.invert = 1'b1; end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures a request, drives the external comparator, reports taken/target, then flushes.
// Latency: response valid two edges after the request handshake; flush lasts FLUSH_CYCLES after a taken response.
// Backpressure: req_ready_o only in IDLE (no queueing); response held stable until resp_ready_i.
module branch_ctrl
    import br_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,   // 1..7, fits the 3-bit flush timer
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      imm_i,
    input  logic [31:0]      rs1_data_i,
    input  logic [31:0]      rs2_data_i,
    output logic [31:0]      cmp_rs1_o,
    output logic [31:0]      cmp_rs2_o,
    output logic             cmp_unsign_o,
    input  logic             cmp_less_i,
    input  logic             cmp_equal_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_taken_o,
    output logic [31:0]      resp_target_o,
    output logic             resp_illegal_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    br_state_t   state_q;
    logic [2:0]  funct3_q;
    logic [31:0] target_q;
    logic [2:0]  flush_tmr_q;
    br_dec_t     dec;
    logic        cmp_pick;
    logic        taken_c;

    // Decode works on the captured funct3 so cmp_unsign_o holds with the operands
    br_decode u_decode (
        .funct3 (funct3_q),
        .dec    (dec)
    );

    assign cmp_unsign_o = dec.unsign;

    // Resolve the taken condition from the comparator results; illegal opcodes never take
    always_comb begin
        cmp_pick = dec.use_less ? cmp_less_i : cmp_equal_i;
        taken_c  = !dec.illegal && (cmp_pick ^ dec.invert);
    end

    // Controller FSM with all outputs registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            req_ready_o    <= 1'b1;
            funct3_q       <= '0;
            target_q       <= '0;
            cmp_rs1_o      <= '0;
            cmp_rs2_o      <= '0;
            resp_valid_o   <= 1'b0;
            resp_taken_o   <= 1'b0;
            resp_illegal_o <= 1'b0;
            resp_target_o  <= '0;
            flush_o        <= 1'b0;
            flush_tmr_q    <= '0;
            taken_cnt_o    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        funct3_q    <= funct3_i;
                        target_q    <= pc_i + imm_i;
                        cmp_rs1_o   <= rs1_data_i;
                        cmp_rs2_o   <= rs2_data_i;
                        req_ready_o <= 1'b0;
                        state_q     <= CMP;
                    end
                end
                CMP: begin
                    resp_valid_o   <= 1'b1;
                    resp_taken_o   <= taken_c;
                    resp_illegal_o <= dec.illegal;
                    resp_target_o  <= target_q;
                    state_q        <= RESP;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        if (resp_taken_o) begin
                            flush_o     <= 1'b1;
                            flush_tmr_q <= 3'(FLUSH_CYCLES - 1);
                            if (taken_cnt_o != '1) begin
                                taken_cnt_o <= taken_cnt_o + CNT_W'(1);
                            end
                            state_q     <= FLUSH;
                        end else begin
                            req_ready_o <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_tmr_q == 3'd0) begin
                        flush_o     <= 1'b0;
                        req_ready_o <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        flush_tmr_q <= flush_tmr_q - 3'd1;
                    end
                end
                default: begin
                    req_ready_o <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: two instances (default counter width and a 2-bit counter) share stimulus.
// Latency: n/a.
// Backpressure: response ready is withheld for a programmable number of cycles per branch.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] pc = '0, imm = '0, rs1 = '0, rs2 = '0;
    logic        resp_ready = 1'b0;

    // instance A: default parameters
    logic        req_ready, cmp_unsign, cmp_less, cmp_equal;
    logic [31:0] cmp_rs1, cmp_rs2, resp_target;
    logic        resp_valid, resp_taken, resp_illegal, flush;
    logic [15:0] taken_cnt;

    // instance B: 2-bit counter
    logic        b_req_ready, b_cmp_unsign, b_cmp_less, b_cmp_equal;
    logic [31:0] b_cmp_rs1, b_cmp_rs2, b_resp_target;
    logic        b_resp_valid, b_resp_taken, b_resp_illegal, b_flush;
    logic [1:0]  b_taken_cnt;

    typedef struct {
        logic        taken;
        logic        illegal;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   exp_cnt = 0;
    int   exp_cnt2 = 0;

    always #5 clk = ~clk;

    // external shared comparators, one per instance
    assign cmp_equal   = (cmp_rs1 == cmp_rs2);
    assign cmp_less    = cmp_unsign ? (cmp_rs1 < cmp_rs2) : ($signed(cmp_rs1) < $signed(cmp_rs2));
    assign b_cmp_equal = (b_cmp_rs1 == b_cmp_rs2);
    assign b_cmp_less  = b_cmp_unsign ? (b_cmp_rs1 < b_cmp_rs2) : ($signed(b_cmp_rs1) < $signed(b_cmp_rs2));

    branch_ctrl u_dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .funct3_i(funct3), .pc_i(pc), .imm_i(imm), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .cmp_rs1_o(cmp_rs1), .cmp_rs2_o(cmp_rs2), .cmp_unsign_o(cmp_unsign),
        .cmp_less_i(cmp_less), .cmp_equal_i(cmp_equal),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_taken_o(resp_taken),
        .resp_target_o(resp_target), .resp_illegal_o(resp_illegal),
        .flush_o(flush), .taken_cnt_o(taken_cnt)
    );

    branch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(b_req_ready),
        .funct3_i(funct3), .pc_i(pc), .imm_i(imm), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .cmp_rs1_o(b_cmp_rs1), .cmp_rs2_o(b_cmp_rs2), .cmp_unsign_o(b_cmp_unsign),
        .cmp_less_i(b_cmp_less), .cmp_equal_i(b_cmp_equal),
        .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready), .resp_taken_o(b_resp_taken),
        .resp_target_o(b_resp_target), .resp_illegal_o(b_resp_illegal),
        .flush_o(b_flush), .taken_cnt_o(b_taken_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // reference branch semantics, written directly from the RV32I definitions
    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // one complete branch: request, comparator phase, stalled response, flush and counter
    task automatic run_branch(input logic [2:0] f3, input logic [31:0] p, input logic [31:0] im,
                              input logic [31:0] a, input logic [31:0] b, input int hold,
                              input bit abort_in_flush);
        exp_t e;
        exp_t got;
        int   cyc;
        int   fl;
        bit   aborted;
        e.taken   = ref_taken(f3, a, b);
        e.illegal = (f3 == 3'b010) || (f3 == 3'b011);
        e.target  = p + im;
        aborted   = 1'b0;

        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; funct3 = f3; pc = p; imm = im; rs1 = a; rs2 = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);

        @(negedge clk);
        chk("cmp_rs1", cmp_rs1, a);
        chk("cmp_rs2", cmp_rs2, b);
        chk("cmp_unsign", cmp_unsign, f3[1]);
        chk("cmp_no_resp", resp_valid, 0);
        chk("cmp_req_ready", req_ready, 0);

        @(negedge clk);
        cyc = 0;
        while (!resp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("resp_latency", cyc, 0);
        got = sb.pop_front();
        chk("resp_taken", resp_taken, got.taken);
        chk("resp_target", resp_target, got.target);
        chk("resp_illegal", resp_illegal, got.illegal);

        // stall the response while offering a request that must be ignored
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'h7; rs2 = 32'h7;
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_taken", resp_taken, got.taken);
            chk("hold_target", resp_target, got.target);
            chk("hold_illegal", resp_illegal, got.illegal);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_cmp_rs1", cmp_rs1, a);
            chk("hold_flush", flush, 0);
        end
        req_valid = 1'b0;

        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        cyc = 0;
        fl  = 0;
        while (!req_ready && cyc < 12) begin
            if (flush) fl++;
            if (abort_in_flush && flush) begin
                rst = 1'b1;
                #1;
                chk("rst_flush_drop", flush, 0);
                chk("rst_cnt_clear", taken_cnt, 0);
                chk("rst_req_ready", req_ready, 1);
                chk("rst_resp_valid", resp_valid, 0);
                aborted = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                exp_cnt = 0;
                exp_cnt2 = 0;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (!aborted) begin
            chk("flush_cycles", fl, got.taken ? 2 : 0);
            if (got.taken) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end
        chk("idle_req_ready", req_ready, 1);
        chk("idle_flush", flush, 0);
        chk("idle_no_resp", resp_valid, 0);
        chk("taken_cnt", taken_cnt, exp_cnt);
        chk("taken_cnt_w2", b_taken_cnt, exp_cnt2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3_tab [8];
        logic [31:0] ra, rb;
        f3_tab = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};

        // reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid0", resp_valid, 0);
        chk("rst_flush0", flush, 0);
        chk("rst_cnt0", taken_cnt, 0);
        chk("rst_cmp_rs1", cmp_rs1, 0);
        chk("rst_cmp_unsign", cmp_unsign, 0);
        chk("rst_target", resp_target, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready0", req_ready, 1);

        // directed cases
        run_branch(3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 0, 1'b0);           // BEQ taken
        run_branch(3'b100, 32'h200, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h1, 0, 1'b0); // BLT taken
        run_branch(3'b110, 32'h200, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h1, 0, 1'b0); // BLTU not taken
        run_branch(3'b010, 32'h300, 32'h4, 32'h1, 32'h1, 0, 1'b0);             // illegal
        run_branch(3'b001, 32'h400, 32'h8, 32'h1, 32'h2, 5, 1'b0);             // BNE, stalled 5
        run_branch(3'b101, 32'hFFFFFFF0, 32'h20, 32'h80000000, 32'h0, 1, 1'b0); // BGE not taken, target wraps
        run_branch(3'b111, 32'h10, 32'h10, 32'h80000000, 32'h0, 0, 1'b0);      // BGEU taken

        // mixed random traffic
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? ra : $urandom;
            run_branch(f3_tab[$urandom_range(0, 7)], $urandom, $urandom, ra, rb,
                       $urandom_range(0, 3), 1'b0);
        end

        // five more taken branches; the 2-bit counter must pin at 3
        for (int i = 0; i < 5; i++) begin
            run_branch(3'b000, 32'h1000, 32'h40, 32'hA, 32'hA, 0, 1'b0);
        end
        chk("cnt_w2_saturated", b_taken_cnt, 3);

        // reset while flushing
        run_branch(3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 0, 1'b1);

        // reset while comparing: no response, no flush, no count
        run_branch(3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'h9; rs2 = 32'h9; pc = 32'h0; imm = 32'h4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        exp_cnt2 = 0;
        begin
            int seen_valid;
            int seen_flush;
            seen_valid = 0;
            seen_flush = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (resp_valid) seen_valid++;
                if (flush) seen_flush++;
            end
            chk("abort_cmp_no_resp", seen_valid, 0);
            chk("abort_cmp_no_flush", seen_flush, 0);
            chk("abort_cmp_cnt", taken_cnt, 0);
            chk("abort_cmp_ready", req_ready, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: cycles flush_o stays high after a taken branch; legal range 1..7.
REQ-002 Parameter CNT_W, default 16: width of the taken-branch counter.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  in  1  branch request valid.
REQ-006 req_ready_o  out  1  controller can accept a request.
REQ-007 funct3_i  in  3  branch opcode (RV32I B-type funct3).
REQ-008 pc_i, imm_i  in  32 each  branch PC and sign-extended offset.
REQ-009 rs1_data_i, rs2_data_i  in  32 each  branch operands.
REQ-010 cmp_rs1_o, cmp_rs2_o  out  32 each  operands driven to the shared comparator.
REQ-011 cmp_unsign_o  out  1  comparator mode; 1 = unsigned, 0 = signed.
REQ-012 cmp_less_i, cmp_equal_i  in  1 each  comparator results, combinational from cmp_*_o.
REQ-013 resp_valid_o / resp_ready_i  out / in  1 each  response handshake.
REQ-014 resp_taken_o  out  1; resp_target_o  out  32; resp_illegal_o  out  1.
REQ-015 flush_o  out  1  pipeline flush.
REQ-016 taken_cnt_o  out  CNT_W  count of taken branches.

Function
REQ-017 The FSM SHALL have four states: IDLE, CMP, RESP, FLUSH.
REQ-018 req_ready_o SHALL be 1 only in IDLE; a handshake occurs when req_valid_i and req_ready_o are both 1 on an edge.
REQ-019 On handshake: register funct3, pc+imm (mod 2^32), rs1 and rs2; go to CMP.
REQ-020 In CMP: cmp_rs1_o/cmp_rs2_o SHALL carry the registered operands; cmp_unsign_o = funct3[1]; sample cmp_less_i/cmp_equal_i at the end of the cycle; go to RESP.
REQ-021 In all other states cmp_*_o SHALL hold their last registered values.
REQ-022 Taken decode: 000 taken = equal; 001 taken = !equal; 100/110 taken = less; 101/111 taken = !less.
REQ-023 funct3 010 or 011 SHALL give resp_illegal_o=1, resp_taken_o=0, and no flush.
REQ-024 In RESP, resp_valid_o=1 and resp_taken_o/resp_target_o/resp_illegal_o SHALL stay stable until resp_ready_i=1.
REQ-025 Latency: the handshake edge is N; resp_valid_o rises in the cycle after edge N+1.
REQ-026 At the RESP handshake: if taken, go to FLUSH and increment taken_cnt_o; otherwise go to IDLE.
REQ-027 taken_cnt_o SHALL saturate at all-ones, with no wrap.
REQ-028 flush_o SHALL be 1 for exactly FLUSH_CYCLES cycles in FLUSH, then the FSM returns to IDLE; flush_o is 0 in every other state.
REQ-029 req_valid_i outside IDLE SHALL be ignored; no request is queued.
REQ-030 resp_ready_i outside RESP SHALL have no effect.

Reset
REQ-031 While rst_i=1: state=IDLE, req_ready_o=1 after release, resp_valid_o=0, resp_taken_o=0, resp_illegal_o=0, resp_target_o=0, cmp_*_o=0, flush_o=0, taken_cnt_o=0, flush timer=0.
REQ-032 Reset mid-operation SHALL abort the branch in flight with no response, no flush and no counter update.

Structure
REQ-033 Shared package br_pkg SHALL hold the funct3 constants (BEQ..BGEU) and the state enum typedef.
REQ-034 One combinational sub-module br_decode SHALL map funct3 to {unsign, use_less, invert, illegal}.
REQ-035 The comparator SHALL sit outside branch_ctrl, wired at the top level.

Verification
REQ-036 BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20 -> resp after 2 cycles, taken=1, target=0x120, flush_o high 2 cycles, taken_cnt_o=1.
REQ-037 BLT, rs1=0xFFFFFFFF, rs2=0x1 -> cmp_unsign_o=0, taken=1; the same operands with BLTU -> cmp_unsign_o=1, taken=0, no flush.
REQ-038 funct3=010 -> resp_illegal_o=1, taken=0, no flush, counter unchanged.
REQ-039 resp_ready_i held low 5 cycles -> resp outputs stable the whole time; req_ready_o=0; a new req_valid_i is ignored.
REQ-040 rst_i pulsed in FLUSH -> flush_o drops immediately; state IDLE; taken_cnt_o=0.
REQ-041 With CNT_W=2, five taken branches -> taken_cnt_o stays at 3.
